// File: rtl/tile_mac_engine.sv
// tile_mac_engine
//   Weight-stationary N x N tile multiply-accumulate engine. A weight tile B is
//   loaded one row (or column, when transposed) per beat. Narrow mode sign-extends
//   8-bit weight lanes. A programmable number of A rows is then streamed through
//   the tile, and each row produces out = addend + a * B (mod 2^DATA_WIDTH).
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   start, abort                job start pulse (IDLE only), synchronous flush
//   cfg_rows/b_trans/b_narrow   job configuration, sampled on accepted start
//   busy, done                  job in progress, one-cycle end-of-job pulse
//   w_valid/w_ready/w_data      weight beats, lane j at [j*DATA_WIDTH +: DATA_WIDTH]
//   a_valid/a_ready/a_data      A rows, with a_addend qualified by a_valid
//   out_valid/out_ready/out_data result rows, in A order
module tile_mac_engine #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned N          = 4,
  parameter int unsigned ROWS_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [ROWS_W-1:0]       cfg_rows,
  input  logic                    cfg_b_trans,
  input  logic                    cfg_b_narrow,
  output logic                    busy,
  output logic                    done,
  input  logic                    w_valid,
  output logic                    w_ready,
  input  logic [N*DATA_WIDTH-1:0] w_data,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [N*DATA_WIDTH-1:0] a_data,
  input  logic [N*DATA_WIDTH-1:0] a_addend,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N*DATA_WIDTH-1:0] out_data
);

  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   b_q     [N][N];
  logic [DATA_WIDTH-1:0]   w_lane  [N];
  logic [DATA_WIDTH-1:0]   prod    [N][N];
  logic [DATA_WIDTH-1:0]   s1_prod [N][N];
  logic [DATA_WIDTH-1:0]   s1_add  [N];
  logic [DATA_WIDTH-1:0]   sum_lane[N];
  logic                    s1_valid;
  logic [ROWS_W-1:0]       rows_q;
  logic [ROWS_W-1:0]       rows_acc;
  logic                    trans_q;
  logic                    narrow_q;
  logic [CNT_W-1:0]        w_cnt;
  logic                    pipe_en;
  logic                    w_fire;
  logic                    a_fire;
  logic                    out_fire;

  // busy and w_ready are decodes of the state register
  assign busy     = (state != IDLE);
  assign w_ready  = (state == LOAD);
  assign pipe_en  = !out_valid || out_ready;
  assign a_ready  = (state == COMPUTE) && pipe_en && (rows_acc < rows_q);
  assign w_fire   = w_valid && w_ready;
  assign a_fire   = a_valid && a_ready;
  assign out_fire = out_valid && out_ready;

  // Incoming weight lanes, optionally sign-extended from the low N bytes
  always_comb begin
    for (int unsigned j = 0; j < N; j++) begin
      w_lane[j] = w_data[j*DATA_WIDTH +: DATA_WIDTH];
      if (narrow_q)
        w_lane[j] = {{(DATA_WIDTH-8){w_data[8*j+7]}}, w_data[8*j +: 8]};
    end
  end

  // Stage-1 products, truncated to lane width
  always_comb begin
    for (int unsigned i = 0; i < N; i++)
      for (int unsigned j = 0; j < N; j++)
        prod[i][j] = a_data[i*DATA_WIDTH +: DATA_WIDTH] * b_q[i][j];
  end

  // Stage-2 column sums, wrapping mod 2^DATA_WIDTH
  always_comb begin
    for (int unsigned j = 0; j < N; j++) begin
      sum_lane[j] = s1_add[j];
      for (int unsigned i = 0; i < N; i++)
        sum_lane[j] = sum_lane[j] + s1_prod[i][j];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      done      <= 1'b0;
      rows_q    <= '0;
      rows_acc  <= '0;
      trans_q   <= 1'b0;
      narrow_q  <= 1'b0;
      w_cnt     <= '0;
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        s1_add[i] <= '0;
        for (int unsigned j = 0; j < N; j++) begin
          b_q[i][j]     <= '0;
          s1_prod[i][j] <= '0;
        end
      end
    end else begin
      done <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        s1_valid  <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (cfg_rows == '0) begin
                done <= 1'b1;
              end else begin
                state    <= LOAD;
                rows_q   <= cfg_rows;
                trans_q  <= cfg_b_trans;
                narrow_q <= cfg_b_narrow;
                w_cnt    <= '0;
                rows_acc <= '0;
              end
            end
          end
          LOAD: begin
            if (w_fire) begin
              for (int unsigned j = 0; j < N; j++) begin
                if (trans_q) b_q[j][w_cnt] <= w_lane[j];
                else         b_q[w_cnt][j] <= w_lane[j];
              end
              w_cnt <= w_cnt + CNT_W'(1);
              if (w_cnt == CNT_W'(N-1)) state <= COMPUTE;
            end
          end
          COMPUTE: begin
            if (a_fire) begin
              rows_acc <= rows_acc + ROWS_W'(1);
              if (rows_acc + ROWS_W'(1) == rows_q) state <= DRAIN;
            end
          end
          DRAIN: begin
            // Stage 1 is always occupied on entry here, so the job ends on the
            // handshake that empties the last occupied stage.
            if (out_fire && !s1_valid) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase

        if (pipe_en) begin
          s1_valid  <= a_fire;
          out_valid <= s1_valid;
          if (a_fire) begin
            for (int unsigned i = 0; i < N; i++) begin
              s1_add[i] <= a_addend[i*DATA_WIDTH +: DATA_WIDTH];
              for (int unsigned j = 0; j < N; j++)
                s1_prod[i][j] <= prod[i][j];
            end
          end
          if (s1_valid) begin
            for (int unsigned j = 0; j < N; j++)
              out_data[j*DATA_WIDTH +: DATA_WIDTH] <= sum_lane[j];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tile_mac_engine.sv
// Directed testbench for tile_mac_engine (N=4, DATA_WIDTH=16).
module tb_tile_mac_engine;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] cfg_rows;
  logic        cfg_b_trans;
  logic        cfg_b_narrow;
  logic        busy;
  logic        done;
  logic        w_valid;
  logic        w_ready;
  logic [63:0] w_data;
  logic        a_valid;
  logic        a_ready;
  logic [63:0] a_data;
  logic [63:0] a_addend;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;

  int n_checks;
  int n_pass;

  logic [63:0] wbeat   [4];
  logic [63:0] arow    [16];
  logic [63:0] addrow  [16];
  logic [63:0] exp_out [16];

  tile_mac_engine #(.DATA_WIDTH(16), .N(4), .ROWS_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_rows(cfg_rows), .cfg_b_trans(cfg_b_trans), .cfg_b_narrow(cfg_b_narrow),
    .busy(busy), .done(done),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_addend(a_addend),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [15:0] rows, input logic trans, input logic narrow);
    cfg_rows     = rows;
    cfg_b_trans  = trans;
    cfg_b_narrow = narrow;
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  task automatic load_weights(input int nbeats);
    for (int k = 0; k < nbeats; k++) begin
      int g;
      w_valid = 1'b1;
      w_data  = wbeat[k];
      #1;
      if (k == 0) check("w_ready_after_start", w_ready, 1'b1);
      g = 0;
      while (!w_ready && g < 20) begin
        tick();
        g++;
      end
      if (g == 20) check("w_ready_timeout", w_ready, 1'b1);
      tick();
    end
    w_valid = 1'b0;
  endtask

  task automatic set_identity();
    wbeat[0] = 64'h0000_0000_0000_0001;
    wbeat[1] = 64'h0000_0000_0001_0000;
    wbeat[2] = 64'h0000_0001_0000_0000;
    wbeat[3] = 64'h0001_0000_0000_0000;
  endtask

  // Streams n rows from arow/addrow, compares each output with exp_out in order,
  // holds out_ready low for stall_len cycles from stall_at.
  task automatic run_rows(input int n, input int stall_at, input int stall_len);
    int sent, got, done_cnt, done_at, last_fire, first_a, first_o, unstable, after;
    logic drop_seen, prev_stall;
    logic [63:0] prev_data;
    sent = 0; got = 0; done_cnt = 0; done_at = -1; last_fire = -2;
    first_a = -1; first_o = -1; unstable = 0; after = 0;
    drop_seen = 1'b0; prev_stall = 1'b0; prev_data = '0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      a_valid   = (sent < n);
      a_data    = arow[sent % 16];
      a_addend  = addrow[sent % 16];
      out_ready = !(stall_len > 0 && cyc >= stall_at && cyc < stall_at + stall_len);
      #1;
      if (cyc == 0) check("a_ready_after_load", a_ready, 1'b1);
      if (prev_stall && out_data !== prev_data) unstable++;
      if (!out_ready && a_valid && !a_ready) drop_seen = 1'b1;
      if (out_valid && first_o < 0) first_o = cyc;
      if (a_valid && a_ready) begin
        if (first_a < 0) first_a = cyc;
        sent++;
      end
      if (out_valid && out_ready) begin
        if (got < 16) check($sformatf("out_row%0d", got), out_data, exp_out[got]);
        got++;
        last_fire = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      tick();
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = cyc;
      end
      if (done_cnt > 0) begin
        after++;
        if (after > 4) break;
      end
    end
    a_valid   = 1'b0;
    out_ready = 1'b1;
    check("out_handshakes", got, n);
    check("done_count", done_cnt, 1);
    check("done_latency", done_at, last_fire);
    check("busy_after_done", busy, 1'b0);
    if (stall_len == 0) check("row_latency", first_o - first_a, 2);
    else begin
      check("stall_stable", unstable, 0);
      check("a_ready_drop", drop_seen, 1'b1);
    end
  endtask

  task automatic job_a();
    for (int k = 0; k < 4; k++) wbeat[k] = {4{16'(k + 1)}};
    arow[0] = 64'h0001_0001_0001_0001;
    addrow[0] = '0;
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_rows = '0; cfg_b_trans = 1'b0; cfg_b_narrow = 1'b0;
    w_valid = 1'b0; w_data = '0; a_valid = 1'b0; a_data = '0; a_addend = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin arow[i] = '0; addrow[i] = '0; exp_out[i] = '0; end

    tick(); tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_w_ready", w_ready, 1'b0);
    check("rst_a_ready", a_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 64'h0);
    rst_n = 1'b1;
    tick();

    // Non-transposed load: column sums 1+2+3+4
    job_a();
    exp_out[0] = 64'h000a_000a_000a_000a;
    start_job(16'd1, 1'b0, 1'b0);
    check("busy_after_start", busy, 1'b1);
    load_weights(4);
    run_rows(1, 0, 0);

    // Transposed load: lane j = 4*(j+1)
    job_a();
    exp_out[0] = 64'h0010_000c_0008_0004;
    start_job(16'd1, 1'b1, 1'b0);
    load_weights(4);
    run_rows(1, 0, 0);

    // Narrow load: diagonal -1
    wbeat[0] = 64'h0000_0000_0000_00ff;
    wbeat[1] = 64'h0000_0000_0000_ff00;
    wbeat[2] = 64'h0000_0000_00ff_0000;
    wbeat[3] = 64'h0000_0000_ff00_0000;
    arow[0]    = 64'h0005_0005_0005_0005;
    addrow[0]  = 64'h0000_0000_0000_0001;
    exp_out[0] = 64'hfffb_fffb_fffb_fffc;
    start_job(16'd1, 1'b0, 1'b1);
    load_weights(4);
    run_rows(1, 0, 0);

    // Wrap-around with identity B
    set_identity();
    arow[0] = 64'h0000_0000_0000_8000; addrow[0] = 64'h0000_0000_0000_8000; exp_out[0] = 64'h0;
    arow[1] = 64'hffff_ffff_ffff_ffff; addrow[1] = 64'h0001_0001_0001_0001; exp_out[1] = 64'h0;
    arow[2] = 64'h0004_0003_0002_0001; addrow[2] = 64'h0010_0010_0010_0010;
    exp_out[2] = 64'h0014_0013_0012_0011;
    start_job(16'd3, 1'b0, 1'b0);
    load_weights(4);
    run_rows(3, 0, 0);

    // Backpressure: 8 rows, out_ready low for 5 cycles mid-stream
    set_identity();
    for (int r = 0; r < 8; r++) begin
      arow[r]    = {16'(r + 30), 16'(r + 20), 16'(r + 10), 16'(r)};
      addrow[r]  = '0;
      exp_out[r] = {16'(r + 30), 16'(r + 20), 16'(r + 10), 16'(r)};
    end
    start_job(16'd8, 1'b0, 1'b0);
    load_weights(4);
    run_rows(8, 4, 5);

    // Zero-row job: immediate done, no weight handshake
    start_job(16'd0, 1'b0, 1'b0);
    check("rows0_done", done, 1'b1);
    check("rows0_busy", busy, 1'b0);
    check("rows0_w_ready", w_ready, 1'b0);
    tick();
    check("rows0_done_pulse", done, 1'b0);
    check("rows0_w_ready_later", w_ready, 1'b0);

    // Abort in COMPUTE after 3 of 8 rows
    set_identity();
    start_job(16'd8, 1'b0, 1'b0);
    load_weights(4);
    begin
      int fired;
      int dcnt;
      int bcnt;
      fired = 0;
      out_ready = 1'b1;
      for (int c = 0; c < 50 && fired < 3; c++) begin
        a_valid = 1'b1;
        a_data  = 64'h0001_0001_0001_0001;
        a_addend = '0;
        #1;
        if (a_ready) fired++;
        tick();
      end
      check("abort_rows_sent", fired, 3);
      a_valid = 1'b0;
      abort = 1'b1;
      start = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      check("abort_busy", busy, 1'b0);
      check("abort_out_valid", out_valid, 1'b0);
      check("abort_a_ready", a_ready, 1'b0);
      check("abort_w_ready", w_ready, 1'b0);
      dcnt = 0;
      bcnt = 0;
      for (int c = 0; c < 6; c++) begin
        if (done) dcnt++;
        if (busy || out_valid) bcnt++;
        tick();
      end
      check("abort_no_done", dcnt, 0);
      check("abort_idle", bcnt, 0);
    end

    // New job after abort
    job_a();
    exp_out[0] = 64'h000a_000a_000a_000a;
    start_job(16'd1, 1'b0, 1'b0);
    load_weights(4);
    run_rows(1, 0, 0);

    // Reset mid-LOAD
    job_a();
    start_job(16'd1, 1'b0, 1'b0);
    w_valid = 1'b1;
    w_data  = wbeat[0];
    tick();
    w_data  = wbeat[1];
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_w_ready", w_ready, 1'b0);
    check("midrst_out_data", out_data, 64'h0);
    check("midrst_out_valid", out_valid, 1'b0);
    w_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
